// File: rtl/axi_resp_err_mon.sv
// AXI B/R response error monitor.
// Counts bad write responses and bad read bursts, captures the first error.
module axi_resp_err_mon #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 pll_core_cpuclk,
  input  logic                 pad_cpu_rst,
  input  logic                 bvalid_s1,
  input  logic                 bready_s1,
  input  logic [1:0]           bresp_s1,
  input  logic [7:0]           bid_s1,
  input  logic                 rvalid_s1,
  input  logic                 rready_s1,
  input  logic [1:0]           rresp_s1,
  input  logic [7:0]           rid_s1,
  input  logic                 rlast_s1,
  input  logic                 err_clr,
  input  logic                 err_irq_en,
  output logic [CNT_WIDTH-1:0] wr_err_cnt,
  output logic [CNT_WIDTH-1:0] rd_err_cnt,
  output logic                 first_err_vld,
  output logic [7:0]           first_err_id,
  output logic                 first_err_rd,
  output logic                 proto_err,
  output logic                 err_irq
);

  typedef enum logic {
    R_IDLE,
    R_BURST
  } r_state_e;

  r_state_e r_state;
  logic [7:0] beat_cnt;
  logic       burst_err;

  logic b_hs;
  logic r_hs;
  logic beat_max;
  logic r_close;
  logic proto_ev;
  logic wr_ev;
  logic rd_ev;
  logic any_ev;
  logic unused_resp;

  logic [CNT_WIDTH-1:0] wr_base;
  logic [CNT_WIDTH-1:0] rd_base;
  logic                 vld_base;

  assign b_hs     = bvalid_s1 & bready_s1;
  assign r_hs     = rvalid_s1 & rready_s1;
  assign beat_max = (beat_cnt == 8'hFF);
  // A 256th non-last beat is forced closed as if it carried rlast.
  assign r_close  = r_hs & (rlast_s1 | beat_max);
  assign proto_ev = r_hs & ~rlast_s1 & beat_max;
  assign wr_ev    = b_hs & bresp_s1[1];
  assign rd_ev    = r_close &
                    (((r_state == R_BURST) & burst_err) | rresp_s1[1]);
  assign any_ev   = wr_ev | rd_ev;

  assign unused_resp = ^{bresp_s1[0], rresp_s1[0]};

  assign wr_base  = err_clr ? '0 : wr_err_cnt;
  assign rd_base  = err_clr ? '0 : rd_err_cnt;
  assign vld_base = err_clr ? 1'b0 : first_err_vld;

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      r_state   <= R_IDLE;
      beat_cnt  <= 8'h00;
      burst_err <= 1'b0;
    end else if (r_hs) begin
      if (r_close) begin
        r_state   <= R_IDLE;
        beat_cnt  <= 8'h00;
        burst_err <= 1'b0;
      end else begin
        r_state   <= R_BURST;
        beat_cnt  <= beat_cnt + 8'h01;
        burst_err <= burst_err | rresp_s1[1];
      end
    end
  end

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      wr_err_cnt    <= '0;
      rd_err_cnt    <= '0;
      first_err_vld <= 1'b0;
      first_err_id  <= 8'h00;
      first_err_rd  <= 1'b0;
      proto_err     <= 1'b0;
      err_irq       <= 1'b0;
    end else begin
      wr_err_cnt <= (wr_ev && wr_base != '1) ?
                    wr_base + CNT_WIDTH'(1) : wr_base;
      rd_err_cnt <= (rd_ev && rd_base != '1) ?
                    rd_base + CNT_WIDTH'(1) : rd_base;
      proto_err  <= (proto_err & ~err_clr) | proto_ev;
      err_irq    <= (err_irq & ~err_clr) | (any_ev & err_irq_en);
      if (!vld_base && any_ev) begin
        first_err_vld <= 1'b1;
        first_err_id  <= wr_ev ? bid_s1 : rid_s1;
        first_err_rd  <= ~wr_ev;
      end else if (err_clr) begin
        first_err_vld <= 1'b0;
        first_err_id  <= 8'h00;
        first_err_rd  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_resp_err_mon.sv
// Scoreboard bench for axi_resp_err_mon.
// Burst-level reference model feeds an expected-state queue.
module tb_axi_resp_err_mon;

  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bvalid = 0, bready = 0, rvalid = 0, rready = 0, rlast = 0;
  logic [1:0] bresp = 0, rresp = 0;
  logic [7:0] bid = 0, rid = 0;
  logic clr = 0, irq_en = 0;

  logic [W-1:0] wr_cnt, rd_cnt;
  logic f_vld, f_rd, proto, irq;
  logic [7:0] f_id;

  axi_resp_err_mon #(.CNT_WIDTH(W)) dut (
    .pll_core_cpuclk(clk),
    .pad_cpu_rst(rst),
    .bvalid_s1(bvalid),
    .bready_s1(bready),
    .bresp_s1(bresp),
    .bid_s1(bid),
    .rvalid_s1(rvalid),
    .rready_s1(rready),
    .rresp_s1(rresp),
    .rid_s1(rid),
    .rlast_s1(rlast),
    .err_clr(clr),
    .err_irq_en(irq_en),
    .wr_err_cnt(wr_cnt),
    .rd_err_cnt(rd_cnt),
    .first_err_vld(f_vld),
    .first_err_id(f_id),
    .first_err_rd(f_rd),
    .proto_err(proto),
    .err_irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       wr;
    int       rd;
    bit       vld;
    bit [7:0] id;
    bit       frd;
    bit       proto;
    bit       irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  bit   beats[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: a read burst is a list of beat error bits.
  always @(posedge clk) begin
    bit wr_ev, rd_ev, pe;
    if (rst) begin
      m = '{0, 0, 0, 8'h00, 0, 0, 0};
      beats.delete();
    end else begin
      wr_ev = bvalid && bready && bresp[1];
      rd_ev = 0;
      pe = 0;
      if (rvalid && rready) begin
        beats.push_back(rresp[1]);
        if (rlast || beats.size() == 256) begin
          foreach (beats[i]) if (beats[i]) rd_ev = 1;
          pe = !rlast;
          beats.delete();
        end
      end
      if (clr) m = '{0, 0, 0, 8'h00, 0, 0, 0};
      if (wr_ev) m.wr = (m.wr < CMAX) ? m.wr + 1 : CMAX;
      if (rd_ev) m.rd = (m.rd < CMAX) ? m.rd + 1 : CMAX;
      if (pe) m.proto = 1;
      if ((wr_ev || rd_ev) && irq_en) m.irq = 1;
      if ((wr_ev || rd_ev) && !m.vld) begin
        m.vld = 1;
        m.id  = wr_ev ? bid : rid;
        m.frd = !wr_ev;
      end
    end
    exp_q.push_back(m);
  end

  task automatic chk(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("queue_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_err_cnt", int'(wr_cnt), e.wr);
        chk("rd_err_cnt", int'(rd_cnt), e.rd);
        chk("first_err_vld", int'(f_vld), int'(e.vld));
        chk("first_err_id", int'(f_id), int'(e.id));
        chk("first_err_rd", int'(f_rd), int'(e.frd));
        chk("proto_err", int'(proto), int'(e.proto));
        chk("err_irq", int'(irq), int'(e.irq));
      end
    end
  end

  task automatic idle(int n);
    bvalid = 0; bready = 0; rvalid = 0; rready = 0;
    rlast = 0; clr = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic b_beat(logic [1:0] resp, logic [7:0] id, logic c);
    bvalid = 1; bready = 1; bresp = resp; bid = id; clr = c;
    rvalid = 0; rready = 0;
    @(negedge clk);
    idle(0);
  endtask

  task automatic r_beat(logic [1:0] resp, logic [7:0] id, logic last);
    rvalid = 1; rready = 1; rresp = resp; rid = id; rlast = last;
    bvalid = 0; bready = 0; clr = 0;
    @(negedge clk);
    idle(0);
  endtask

  task automatic do_clr();
    idle(0);
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    irq_en = 1;
    idle(1);
    // Single bad write response.
    b_beat(2'b10, 8'h5A, 0);
    idle(2);
    do_clr();
    // Four-beat bad read burst.
    for (int i = 0; i < 4; i++) r_beat(2'b10, 8'h33, i == 3);
    idle(2);
    do_clr();
    // Stalled bad last beat.
    rvalid = 1; rready = 0; rresp = 2'b11; rid = 8'h44; rlast = 1;
    repeat (10) @(negedge clk);
    r_beat(2'b11, 8'h44, 1);
    idle(1);
    do_clr();
    // Write and read errors in the same cycle.
    bvalid = 1; bready = 1; bresp = 2'b10; bid = 8'h01;
    rvalid = 1; rready = 1; rresp = 2'b10; rid = 8'h02; rlast = 1;
    @(negedge clk);
    idle(2);
    do_clr();
    // Overlong burst.
    for (int i = 0; i < 257; i++) r_beat(2'b00, 8'h10, 0);
    r_beat(2'b10, 8'h10, 1);
    idle(2);
    do_clr();
    // Saturation then clear with a concurrent error.
    for (int i = 0; i < 16; i++) b_beat(2'b11, 8'(i), 0);
    idle(1);
    b_beat(2'b10, 8'h77, 1);
    idle(1);
    // Errors with interrupts disabled, then re-enabled.
    do_clr();
    irq_en = 0;
    b_beat(2'b10, 8'h20, 0);
    r_beat(2'b01, 8'h21, 1);
    irq_en = 1;
    r_beat(2'b00, 8'h22, 1);
    b_beat(2'b11, 8'h23, 0);
    irq_en = 0;
    idle(2);
    // Reset mid-burst abandons the burst.
    do_clr();
    r_beat(2'b10, 8'h30, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    r_beat(2'b00, 8'h31, 1);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      bvalid = 1'($urandom); bready = 1'($urandom);
      bresp = 2'($urandom); bid = 8'($urandom);
      rvalid = 1'($urandom); rready = 1'($urandom);
      rresp = 2'($urandom); rid = 8'($urandom);
      rlast = ($urandom % 4 == 0);
      clr = ($urandom % 40 == 0);
      if ($urandom % 8 == 0) irq_en = 1'($urandom);
      rst = ($urandom % 300 == 0);
      @(negedge clk);
    end
    rst = 0;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_resp_err_mon.md
AXI_RESP_ERR_MON -- requirements
Module: axi_resp_err_mon

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of each error counter.
REQ-002 pll_core_cpuclk  in  1  sole clock; all state updates on its rising edge.
REQ-003 pad_cpu_rst  in  1  reset, asynchronous, active-high.
REQ-004 bvalid_s1  in  1  AXI B valid, slave-1 port.
REQ-005 bready_s1  in  1  AXI B ready, slave-1 port.
REQ-006 bresp_s1  in  2  AXI B response.
REQ-007 bid_s1  in  8  AXI B ID.
REQ-008 rvalid_s1  in  1  AXI R valid.
REQ-009 rready_s1  in  1  AXI R ready.
REQ-010 rresp_s1  in  2  AXI R response.
REQ-011 rid_s1  in  8  AXI R ID.
REQ-012 rlast_s1  in  1  AXI R last beat.
REQ-013 err_clr  in  1  synchronous clear of counters, capture and IRQ.
REQ-014 err_irq_en  in  1  interrupt enable.
REQ-015 wr_err_cnt  out  CNT_WIDTH  count of erroneous write responses.
REQ-016 rd_err_cnt  out  CNT_WIDTH  count of read bursts with at least one erroneous beat.
REQ-017 first_err_vld  out  1  first-error capture valid.
REQ-018 first_err_id  out  8  ID of first captured error.
REQ-019 first_err_rd  out  1  first captured error was a read (1) or a write (0).
REQ-020 proto_err  out  1  sticky: read burst exceeded 256 beats without rlast_s1.
REQ-021 err_irq  out  1  level interrupt.

Function
REQ-022 Passive monitor: no input is driven or back-pressured; observation only.
REQ-023 B handshake = bvalid_s1 & bready_s1; R handshake = rvalid_s1 & rready_s1; no other cycle has effect.
REQ-024 Error response = resp[1]==1 (SLVERR 2'b10, DECERR 2'b11); OKAY and EXOKAY are not errors.
REQ-025 Each B handshake with an error response increments wr_err_cnt by 1 on the following edge.
REQ-026 Read tracking FSM, states R_IDLE and R_BURST: R_IDLE->R_BURST on an R handshake with rlast_s1=0; R_BURST->R_IDLE on an R handshake with rlast_s1=1; single-beat burst (rlast_s1=1 in R_IDLE) stays in R_IDLE.
REQ-027 Internal burst error flag sets on any erroneous R beat; clears when the burst closes.
REQ-028 On the rlast_s1 handshake, rd_err_cnt increments by 1 if the flag is set or the last beat is erroneous: exactly one count per burst regardless of the number of bad beats.
REQ-029 8-bit beat counter: resets at burst close, increments per non-last beat; a non-last beat at count 255 sets proto_err, closes the burst (counted per REQ-028 as if rlast), returns the FSM to R_IDLE.
REQ-030 Both counters saturate at all-ones; no wrap.
REQ-031 First error capture: when first_err_vld=0 and an error event occurs (write B error, or read burst counted per REQ-028), load first_err_id/first_err_rd and set first_err_vld; hold until err_clr.
REQ-032 Same-cycle write and read error events: both counters increment; capture takes the write (first_err_rd=0, bid_s1).
REQ-033 err_irq sets the edge after any counted error event while err_irq_en=1; it remains set even if err_irq_en later drops; it clears only on err_clr.
REQ-034 err_clr zeroes counters, first_err_*, proto_err, err_irq; an error event in the same cycle is applied after the clear (counter reads 1, capture loads, IRQ sets if enabled); err_clr does not reset the read FSM or the beat counter.
REQ-035 All outputs are registered; latency from handshake to output update is one cycle.

Reset
REQ-036 While pad_cpu_rst=1: counters 0, first_err_vld 0, first_err_id 0, first_err_rd 0, proto_err 0, err_irq 0, FSM R_IDLE, beat counter 0, burst flag 0; an asserting reset mid-burst abandons the burst with no count.

Verification
REQ-037 Write: B handshake with bresp_s1=2'b10, bid_s1=8'h5A, err_irq_en=1 -> next cycle wr_err_cnt=1, first_err_vld=1, first_err_id=8'h5A, first_err_rd=0, err_irq=1.
REQ-038 Read: 4-beat burst, rid_s1=8'h33, rresp_s1=2'b10 on all beats -> rd_err_cnt=1 only after the rlast beat; capture is 8'h33/rd.
REQ-039 Stall: rvalid_s1=1, rready_s1=0 for 10 cycles with an error response -> no change; error counted after the handshake completes.
REQ-040 Same cycle: B error (id 8'h01) plus R last error (id 8'h02) -> both counts +1; first_err_id=8'h01, first_err_rd=0.
REQ-041 257 non-last R beats -> proto_err=1 after the 256th; burst closed; the next beat starts a new burst.
REQ-042 Preload wr_err_cnt to saturation (CNT_WIDTH=4: 15 errors) plus 1 more -> stays 4'hF; err_clr with a concurrent B error -> wr_err_cnt=1.
